// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operand/opcode sequencer: ALU operation codes,
// instruction opcode/funct encodings, datapath widths and the FSM state type.
package alu_op_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int OPRN_W = 6;

  localparam logic [OPRN_W-1:0] OPRN_NOP = 6'h00;
  localparam logic [OPRN_W-1:0] OPRN_ADD = 6'h01;
  localparam logic [OPRN_W-1:0] OPRN_SUB = 6'h02;
  localparam logic [OPRN_W-1:0] OPRN_MUL = 6'h03;
  localparam logic [OPRN_W-1:0] OPRN_SHR = 6'h04;
  localparam logic [OPRN_W-1:0] OPRN_SHL = 6'h05;
  localparam logic [OPRN_W-1:0] OPRN_AND = 6'h06;
  localparam logic [OPRN_W-1:0] OPRN_OR  = 6'h07;
  localparam logic [OPRN_W-1:0] OPRN_NOR = 6'h08;
  localparam logic [OPRN_W-1:0] OPRN_SLT = 6'h09;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_MULI  = 6'h1D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_t;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [15:0] imm);
    logic signed [15:0] imm_s;
    imm_s = $signed(imm);
    return DATA_W'(imm_s);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational instruction decode: opcode/funct/immediate to ALU operation
// code and operand pair, flagging encodings the ALU interface does not serve.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [OPRN_W-1:0] oprn,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              illegal
);

  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;
  logic [DATA_W-1:0] shamt_zx;

  assign imm_sx   = sext_imm(imm);
  assign imm_zx   = {16'b0, imm};
  assign shamt_zx = {27'b0, shamt};

  always_comb begin
    oprn    = OPRN_NOP;
    op1     = rs_data;
    op2     = rt_data;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD: oprn = OPRN_ADD;
          FN_SUB: oprn = OPRN_SUB;
          FN_MUL: oprn = OPRN_MUL;
          FN_AND: oprn = OPRN_AND;
          FN_OR:  oprn = OPRN_OR;
          FN_NOR: oprn = OPRN_NOR;
          FN_SLT: oprn = OPRN_SLT;
          // Shifts operate on rt, with the shift distance taken from shamt.
          FN_SRL: begin oprn = OPRN_SHR; op1 = rt_data; op2 = shamt_zx; end
          FN_SLL: begin oprn = OPRN_SHL; op1 = rt_data; op2 = shamt_zx; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_LW, OPC_SW: begin oprn = OPRN_ADD; op2 = imm_sx; end
      OPC_MULI: begin oprn = OPRN_MUL; op2 = imm_sx; end
      OPC_SLTI: begin oprn = OPRN_SLT; op2 = imm_sx; end
      OPC_ANDI: begin oprn = OPRN_AND; op2 = imm_zx; end
      OPC_ORI:  begin oprn = OPRN_OR;  op2 = imm_zx; end
      // lui is realised as imm << 16 on the shifter.
      OPC_LUI:  begin oprn = OPRN_SHL; op1 = imm_zx; op2 = 32'd16; end
      OPC_BEQ, OPC_BNE: oprn = OPRN_SUB;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op1 = '0;
      op2 = '0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU interface: accepts a decoded instruction, holds
// operands on the combinational ALU for a settle time, returns OUT/ZERO.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [5:0]  REQ_OPCODE,
  input  logic [5:0]  REQ_FUNCT,
  input  logic [4:0]  REQ_SHAMT,
  input  logic [15:0] REQ_IMM,
  input  logic [31:0] REQ_RS_DATA,
  input  logic [31:0] REQ_RT_DATA,
  output logic [31:0] ALU_OP1,
  output logic [31:0] ALU_OP2,
  output logic [5:0]  ALU_OPRN,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_ZERO,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RESULT,
  output logic        RSP_ZERO,
  output logic        RSP_ILLEGAL
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_ready_nxt, rsp_valid_nxt, rsp_zero_nxt, rsp_illegal_nxt;
  logic [31:0]       op1_nxt, op2_nxt, rsp_result_nxt;
  logic [5:0]        oprn_nxt;

  logic [OPRN_W-1:0] dec_oprn;
  logic [DATA_W-1:0] dec_op1, dec_op2;
  logic              dec_illegal;

  alu_op_decode u_decode (
    .opcode  (REQ_OPCODE),
    .funct   (REQ_FUNCT),
    .shamt   (REQ_SHAMT),
    .imm     (REQ_IMM),
    .rs_data (REQ_RS_DATA),
    .rt_data (REQ_RT_DATA),
    .oprn    (dec_oprn),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    req_ready_nxt   = REQ_READY;
    rsp_valid_nxt   = RSP_VALID;
    rsp_result_nxt  = RSP_RESULT;
    rsp_zero_nxt    = RSP_ZERO;
    rsp_illegal_nxt = RSP_ILLEGAL;
    op1_nxt         = ALU_OP1;
    op2_nxt         = ALU_OP2;
    oprn_nxt        = ALU_OPRN;
    case (state)
      ST_IDLE: begin
        if (REQ_VALID) begin
          req_ready_nxt = 1'b0;
          if (dec_illegal) begin
            rsp_illegal_nxt = 1'b1;
            rsp_result_nxt  = '0;
            rsp_zero_nxt    = 1'b0;
            rsp_valid_nxt   = 1'b1;
            state_nxt       = ST_RESP;
          end else begin
            op1_nxt   = dec_op1;
            op2_nxt   = dec_op2;
            oprn_nxt  = dec_oprn;
            cnt_nxt   = CNT_LOAD;
            state_nxt = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          rsp_result_nxt = ALU_OUT;
          rsp_zero_nxt   = ALU_ZERO;
          rsp_valid_nxt  = 1'b1;
          state_nxt      = ST_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // REQ_READY rises only after the acceptance edge, so no back-to-back accept.
        if (RSP_READY) begin
          rsp_valid_nxt   = 1'b0;
          rsp_illegal_nxt = 1'b0;
          oprn_nxt        = OPRN_NOP;
          req_ready_nxt   = 1'b1;
          state_nxt       = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      REQ_READY   <= 1'b1;
      RSP_VALID   <= 1'b0;
      RSP_RESULT  <= '0;
      RSP_ZERO    <= 1'b0;
      RSP_ILLEGAL <= 1'b0;
      ALU_OP1     <= '0;
      ALU_OP2     <= '0;
      ALU_OPRN    <= OPRN_NOP;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      REQ_READY   <= req_ready_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      RSP_RESULT  <= rsp_result_nxt;
      RSP_ZERO    <= rsp_zero_nxt;
      RSP_ILLEGAL <= rsp_illegal_nxt;
      ALU_OP1     <= op1_nxt;
      ALU_OP2     <= op2_nxt;
      ALU_OPRN    <= oprn_nxt;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU drives ALU_OUT/ZERO, and an
// instruction-semantics model predicts operands, result, flags and latency.
module tb_alu_op_sequencer;

  localparam int SETTLE = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [5:0]  REQ_OPCODE = '0;
  logic [5:0]  REQ_FUNCT = '0;
  logic [4:0]  REQ_SHAMT = '0;
  logic [15:0] REQ_IMM = '0;
  logic [31:0] REQ_RS_DATA = '0;
  logic [31:0] REQ_RT_DATA = '0;
  logic [31:0] ALU_OP1, ALU_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RESULT;
  logic        RSP_ZERO;
  logic        RSP_ILLEGAL;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPCODE(REQ_OPCODE), .REQ_FUNCT(REQ_FUNCT), .REQ_SHAMT(REQ_SHAMT),
    .REQ_IMM(REQ_IMM), .REQ_RS_DATA(REQ_RS_DATA), .REQ_RT_DATA(REQ_RT_DATA),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RESULT(RSP_RESULT), .RSP_ZERO(RSP_ZERO), .RSP_ILLEGAL(RSP_ILLEGAL)
  );

  // Behavioural combinational ALU attached to the DUT.
  always_comb begin
    ALU_OUT = '0;
    case (ALU_OPRN)
      6'h01: ALU_OUT = ALU_OP1 + ALU_OP2;
      6'h02: ALU_OUT = ALU_OP1 - ALU_OP2;
      6'h03: ALU_OUT = ALU_OP1 * ALU_OP2;
      6'h04: ALU_OUT = ALU_OP1 >> ALU_OP2[4:0];
      6'h05: ALU_OUT = ALU_OP1 << ALU_OP2[4:0];
      6'h06: ALU_OUT = ALU_OP1 & ALU_OP2;
      6'h07: ALU_OUT = ALU_OP1 | ALU_OP2;
      6'h08: ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'h09: ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: ALU_OUT = '0;
    endcase
    ALU_ZERO = (ALU_OUT == '0);
  end

  typedef struct {
    logic        ill;
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
  } exp_t;

  function automatic exp_t mk(input logic [5:0] oprn, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] res);
    exp_t e;
    e.ill = 1'b0; e.oprn = oprn; e.op1 = op1; e.op2 = op2; e.res = res;
    return e;
  endfunction

  // Instruction semantics: what the instruction means, and which operands it should present.
  function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [15:0] imm,
                                 input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] sx, zx, sh32;
    sx   = {{16{imm[15]}}, imm};
    zx   = {16'h0, imm};
    sh32 = {27'h0, sh};
    e.ill = 1'b1; e.oprn = 6'h00; e.op1 = '0; e.op2 = '0; e.res = '0;
    if (opc == 6'h00) begin
      if      (fn == 6'h20) e = mk(6'h01, rs, rt, rs + rt);
      else if (fn == 6'h22) e = mk(6'h02, rs, rt, rs - rt);
      else if (fn == 6'h2C) e = mk(6'h03, rs, rt, rs * rt);
      else if (fn == 6'h24) e = mk(6'h06, rs, rt, rs & rt);
      else if (fn == 6'h25) e = mk(6'h07, rs, rt, rs | rt);
      else if (fn == 6'h27) e = mk(6'h08, rs, rt, ~(rs | rt));
      else if (fn == 6'h2A) e = mk(6'h09, rs, rt, {31'h0, $signed(rs) < $signed(rt)});
      else if (fn == 6'h02) e = mk(6'h04, rt, sh32, rt >> sh);
      else if (fn == 6'h00) e = mk(6'h05, rt, sh32, rt << sh);
    end
    else if (opc == 6'h08 || opc == 6'h23 || opc == 6'h2B) e = mk(6'h01, rs, sx, rs + sx);
    else if (opc == 6'h1D) e = mk(6'h03, rs, sx, rs * sx);
    else if (opc == 6'h0A) e = mk(6'h09, rs, sx, {31'h0, $signed(rs) < $signed(sx)});
    else if (opc == 6'h0C) e = mk(6'h06, rs, zx, rs & zx);
    else if (opc == 6'h0D) e = mk(6'h07, rs, zx, rs | zx);
    else if (opc == 6'h0F) e = mk(6'h05, zx, 32'd16, {imm, 16'h0});
    else if (opc == 6'h04 || opc == 6'h05) e = mk(6'h02, rs, rt, rs - rt);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One full transaction; RSP_READY held low for wait_cyc cycles once the response appears.
  task automatic run_op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                        input int wait_cyc);
    exp_t e;
    int lat;
    logic [31:0] held;
    e = model(opc, fn, sh, imm, rs, rt);
    check("req_ready_idle", {31'h0, REQ_READY}, 32'd1);
    REQ_OPCODE = opc; REQ_FUNCT = fn; REQ_SHAMT = sh; REQ_IMM = imm;
    REQ_RS_DATA = rs; REQ_RT_DATA = rt; REQ_VALID = 1'b1;
    RSP_READY = (wait_cyc == 0);
    tick();
    lat = 1;
    check("req_ready_busy", {31'h0, REQ_READY}, 32'd0);
    // Keep REQ_VALID asserted with scrambled fields: the sequencer must ignore it.
    REQ_RS_DATA = $urandom; REQ_RT_DATA = $urandom; REQ_IMM = 16'($urandom);
    if (!e.ill) begin
      check("alu_oprn", {26'h0, ALU_OPRN}, {26'h0, e.oprn});
      check("alu_op1", ALU_OP1, e.op1);
      check("alu_op2", ALU_OP2, e.op2);
    end else begin
      check("ill_oprn", {26'h0, ALU_OPRN}, 32'd0);
    end
    while (!RSP_VALID && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, e.ill ? 32'd1 : 32'(SETTLE + 1));
    check("rsp_result", RSP_RESULT, e.ill ? 32'd0 : e.res);
    check("rsp_zero", {31'h0, RSP_ZERO}, (!e.ill && e.res == 0) ? 32'd1 : 32'd0);
    check("rsp_illegal", {31'h0, RSP_ILLEGAL}, {31'h0, e.ill});
    held = RSP_RESULT;
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      check("bp_valid", {31'h0, RSP_VALID}, 32'd1);
      check("bp_result", RSP_RESULT, held);
      check("bp_req_ready", {31'h0, REQ_READY}, 32'd0);
    end
    RSP_READY = 1'b1;
    tick();
    check("acc_valid", {31'h0, RSP_VALID}, 32'd0);
    check("acc_req_ready", {31'h0, REQ_READY}, 32'd1);
    check("acc_oprn", {26'h0, ALU_OPRN}, 32'd0);
    check("acc_illegal", {31'h0, RSP_ILLEGAL}, 32'd0);
    REQ_VALID = 1'b0;
    RSP_READY = 1'b0;
  endtask

  localparam int N_OPC = 13;
  logic [5:0] opc_tab [N_OPC] = '{6'h00, 6'h00, 6'h08, 6'h1D, 6'h0A, 6'h23, 6'h2B,
                                  6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h3E};
  localparam int N_FN = 10;
  logic [5:0] fn_tab [N_FN] = '{6'h20, 6'h22, 6'h2C, 6'h24, 6'h25, 6'h27, 6'h2A,
                                6'h02, 6'h00, 6'h3F};

  initial begin
    logic [31:0] rs, rt;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", {31'h0, REQ_READY}, 32'd1);
    check("rst_rsp_valid", {31'h0, RSP_VALID}, 32'd0);
    check("rst_rsp_result", RSP_RESULT, 32'd0);
    check("rst_alu_op1", ALU_OP1, 32'd0);
    check("rst_alu_op2", ALU_OP2, 32'd0);
    check("rst_alu_oprn", {26'h0, ALU_OPRN}, 32'd0);
    RST = 1'b0;

    run_op(6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'd7, 0);
    run_op(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h10, 32'h0, 0);
    run_op(6'h0D, 6'h00, 5'd0, 16'h8000, 32'h0, 32'h0, 1);
    run_op(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD, 32'h0, 0);
    run_op(6'h04, 6'h00, 5'd0, 16'h0000, 32'hA5, 32'hA5, 0);
    run_op(6'h00, 6'h3F, 5'd0, 16'h0000, 32'h1, 32'h2, 0);
    run_op(6'h00, 6'h20, 5'd0, 16'h0000, 32'd100, 32'd23, 5);
    run_op(6'h00, 6'h02, 5'd4, 16'h0000, 32'h0, 32'hF000_0000, 0);

    // Reset while the ALU is being driven discards the transaction.
    REQ_OPCODE = 6'h00; REQ_FUNCT = 6'h22; REQ_RS_DATA = 32'd9; REQ_RT_DATA = 32'd3;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    check("mid_drive_oprn", {26'h0, ALU_OPRN}, 32'h02);
    RST = 1'b1;
    tick();
    check("rst_mid_req_ready", {31'h0, REQ_READY}, 32'd1);
    check("rst_mid_rsp_valid", {31'h0, RSP_VALID}, 32'd0);
    check("rst_mid_oprn", {26'h0, ALU_OPRN}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check("post_rst_rsp_valid", {31'h0, RSP_VALID}, 32'd0);
    check("post_rst_req_ready", {31'h0, REQ_READY}, 32'd1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] opc, fn;
      opc = opc_tab[$urandom_range(N_OPC - 1)];
      if ($urandom_range(7) == 0) opc = 6'($urandom);
      fn = fn_tab[$urandom_range(N_FN - 1)];
      rs = $urandom;
      rt = ($urandom_range(3) == 0) ? rs : $urandom;
      run_op(opc, fn, 5'($urandom), 16'($urandom), rs, rt, $urandom_range(3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
